i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//  I2C target with a register-pointer protocol, fully synchronous to the system clock.
//  SCL/SDA are oversampled (not used as clocks); START, repeated START and STOP are detected in any state.
//  Writes/reads an external register bank via a one-cycle strobe interface; pointer auto-increments.
//  Sits between the open-drain pad cells and the device register file.
// PARAMETERS
//  SLAVE_ADDRESS  7'b1011010  7-bit target address, compared against bits [7:1] of the first byte.
//  PTR_W          4           register pointer width; bank depth = 2**PTR_W.
//  SYNC_STAGES    2           synchroniser flops on scl_in/sda_in (min 2).
//  FILT_LEN       3           consecutive equal samples required before a filtered line changes.
// PORTS
//  clk         in   1      system clock; must be >= 16x SCL frequency.
//  rst_        in   1      reset: synchronous, active-low.
//  scl_in      in   1      raw SCL from pad.
//  sda_in      in   1      raw SDA from pad.
//  sda_out     out  1      0 = pull SDA low, 1 = release; reset 1.
//  busy        out  1      1 from addressed START until STOP/mismatch/NACK; reset 0.
//  reg_addr    out  PTR_W  current register pointer; reset 0.
//  reg_wdata   out  8      received data byte; valid with reg_wr; reset 0.
//  reg_wr      out  1      one-clk write strobe; reset 0.
//  reg_rd      out  1      one-clk read strobe; reg_rdata sampled on the following clk; reset 0.
//  reg_rdata   in   8      read data from register bank.
// BEHAVIOUR
//  - Lines: SYNC_STAGES flops then FILT_LEN-sample filter; filtered lines reset to 1. SCL rise/fall = 1-clk pulses.
//  - START: filtered SDA falls while SCL high; STOP: SDA rises while SCL high. Data sampled on SCL rise, MSB first.
//  - sda_out changes only FILT_LEN+2 clks after SCL fall, never while SCL high.
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, WAIT_STOP.
//  - Any state: START -> ADDR (bit_cnt=0, sda_out=1); STOP -> IDLE (sda_out=1, busy=0). START wins if both same clk.
//  - ADDR: 8 bits. On 8th rise: match & R/W=0 -> ADDR_ACK then PTR; match & R/W=1 -> ADDR_ACK then RDATA;
//    mismatch -> WAIT_STOP, sda_out stays 1. busy set on match.
//  - *_ACK (ADDR_ACK/PTR_ACK/WACK): drive 0 for the 9th SCL low+high; release after the 9th fall.
//  - PTR: 8 bits; on 8th rise pointer <= byte[PTR_W-1:0] (upper bits ignored); -> PTR_ACK -> WDATA.
//  - WDATA: on 8th rise reg_wdata<=byte, reg_wr pulses next clk with reg_addr=ptr; ptr increments the clk after;
//    -> WACK -> WDATA. Pointer wraps 2**PTR_W-1 -> 0.
//  - RDATA entry (after ACK fall): reg_rd pulses, reg_rdata latched next clk into shift reg; MSB driven before next SCL rise.
//    Bits 6..0 shifted out on successive falls; after 8th fall release SDA -> RACK.
//  - RACK: sample SDA on 9th rise; 0 (ACK) -> ptr++ then RDATA; 1 (NACK) -> WAIT_STOP, busy=0.
//  - WAIT_STOP: sda_out=1, ignore bits, leave only on START/STOP.
//  - Reset mid-transfer: all outputs to reset values, state IDLE, SDA released that clk; no strobes until next START.
//  - bit_cnt 3-bit, 0..7 per byte; ACK is a separate state, no 9th count.
// STRUCTURE
//  - Package i2c_pkg: state enum, ACK/NACK constants, RW_READ/RW_WRITE bit values.
//  - Sub-module i2c_line_sync: synchroniser + glitch filter + SCL edge / START / STOP pulse generation.
//  - Top: FSM, bit counter, shift registers, pointer, strobe logic.
// TESTING
//  - Write: S 0xB4 0x03 0x5A 0xC3 P -> ACKs on all 4 bytes; reg_wr @addr3=0x5A, @addr4=0xC3; busy low after P.
//  - Read: S 0xB4 0x0F Sr 0xB5, master ACK then NACK, P -> reg_rd at 15 then 0 (wrap); SDA carries bank[15],bank[0].
//  - Mismatch: S 0xB6 0x11 P -> no ACK (SDA never low), no strobes, busy stays 0.
//  - Glitch: 1-clk SDA pulse while SCL high mid-byte -> no START/STOP detected, byte received intact.
//  - Reset: rst_ low during 4th data bit of a read -> sda_out=1 same clk, state IDLE; next S 0xB4.. works.
//  - Early STOP: P after 3 bits of data byte -> no reg_wr, IDLE, pointer unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register-pointer target.
package i2c_pkg;

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWack, StRdata, StRack, StWaitStop
   } state_e;

   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises and glitch-filters the raw SCL/SDA pad inputs and derives
// SCL edge, START and STOP pulses from the filtered lines.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic clk,
   input  logic rst_,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   localparam int unsigned CW = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] CntLast = CW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic [CW-1:0]          scl_cnt_q, sda_cnt_q;
   logic                   scl_q, sda_q, scl_prev_q, sda_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_cnt_q  <= '0;
         sda_cnt_q  <= '0;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_q;
         sda_prev_q <= sda_q;
         // A filtered line flips only after FILT_LEN consecutive disagreeing samples.
         if (scl_sync_q[SYNC_STAGES-1] == scl_q) begin
            scl_cnt_q <= '0;
         end else if (scl_cnt_q == CntLast) begin
            scl_q     <= ~scl_q;
            scl_cnt_q <= '0;
         end else begin
            scl_cnt_q <= scl_cnt_q + CW'(1);
         end
         if (sda_sync_q[SYNC_STAGES-1] == sda_q) begin
            sda_cnt_q <= '0;
         end else if (sda_cnt_q == CntLast) begin
            sda_q     <= ~sda_q;
            sda_cnt_q <= '0;
         end else begin
            sda_cnt_q <= sda_cnt_q + CW'(1);
         end
      end
   end

   assign sda      = sda_q;
   assign scl_rise = scl_q & ~scl_prev_q;
   assign scl_fall = ~scl_q & scl_prev_q;
   assign start    = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
   assign stop     = scl_q & scl_prev_q & ~sda_prev_q & sda_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with an auto-incrementing register pointer, accessing an external
// register bank through one-cycle write/read strobes.
module i2c_slave_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDRESS = 7'b1011010,
   parameter int unsigned PTR_W         = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILT_LEN      = 3
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_out,
   output logic             busy,
   output logic [PTR_W-1:0] reg_addr,
   output logic [7:0]       reg_wdata,
   output logic             reg_wr,
   output logic             reg_rd,
   input  logic [7:0]       reg_rdata
);

   localparam int unsigned DRV_DLY = FILT_LEN + 2;
   localparam int unsigned DW      = $clog2(DRV_DLY + 1);

   state_e          state_q;
   logic [2:0]      bit_cnt_q;
   logic [6:0]      rx_q;
   logic [7:0]      tx_q;
   logic            rw_q;
   logic            ack_rise_q;
   logic [DW-1:0]   drv_cnt_q;
   logic            sda_f, scl_rise, scl_fall, start, stop;
   logic [7:0]      rx_byte;
   logic            drive_val;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_line_sync (
      .clk      (clk),
      .rst_     (rst_),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda      (sda_f),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign rx_byte = {rx_q, sda_f};

   // Value SDA should settle to once the post-fall hold delay expires.
   always_comb begin
      drive_val = NACK;
      unique case (state_q)
         StAddrAck, StPtrAck, StWack: drive_val = ACK;
         StRdata:                     drive_val = tx_q[7];
         default:                     drive_val = NACK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         rw_q       <= 1'b0;
         ack_rise_q <= 1'b0;
         drv_cnt_q  <= '0;
         sda_out    <= 1'b1;
         busy       <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_wr     <= 1'b0;
         reg_rd     <= 1'b0;
      end else begin
         reg_wr <= 1'b0;
         reg_rd <= 1'b0;
         if (reg_wr) reg_addr <= reg_addr + 1'b1;
         if (reg_rd) tx_q <= reg_rdata;

         if (scl_fall) begin
            drv_cnt_q <= DW'(DRV_DLY);
         end else if (drv_cnt_q != '0) begin
            drv_cnt_q <= drv_cnt_q - 1'b1;
            if (drv_cnt_q == DW'(1)) sda_out <= drive_val;
         end

         if (start) begin
            state_q    <= StAddr;
            bit_cnt_q  <= '0;
            ack_rise_q <= 1'b0;
            drv_cnt_q  <= '0;
            sda_out    <= 1'b1;
         end else if (stop) begin
            state_q   <= StIdle;
            drv_cnt_q <= '0;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
         end else begin
            unique case (state_q)
               StAddr, StPtr, StWdata: begin
                  if (scl_rise) begin
                     rx_q      <= rx_byte[6:0];
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 3'd7) begin
                        if (state_q == StAddr) begin
                           if (rx_byte[7:1] == SLAVE_ADDRESS) begin
                              busy    <= 1'b1;
                              rw_q    <= rx_byte[0];
                              state_q <= StAddrAck;
                           end else begin
                              busy    <= 1'b0;
                              state_q <= StWaitStop;
                           end
                        end else if (state_q == StPtr) begin
                           reg_addr <= rx_byte[PTR_W-1:0];
                           state_q  <= StPtrAck;
                        end else begin
                           reg_wdata <= rx_byte;
                           reg_wr    <= 1'b1;
                           state_q   <= StWack;
                        end
                     end
                  end
               end
               StAddrAck, StPtrAck, StWack: begin
                  // Leave on the fall that follows the ACK clock's rise (9th fall).
                  if (scl_rise) begin
                     ack_rise_q <= 1'b1;
                  end else if (scl_fall && ack_rise_q) begin
                     ack_rise_q <= 1'b0;
                     bit_cnt_q  <= '0;
                     if (state_q == StAddrAck && rw_q == RW_READ) begin
                        reg_rd  <= 1'b1;
                        state_q <= StRdata;
                     end else if (state_q == StAddrAck) begin
                        state_q <= StPtr;
                     end else begin
                        state_q <= StWdata;
                     end
                  end
               end
               StRdata: begin
                  if (scl_fall) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 3'd7) state_q <= StRack;
                     else tx_q <= {tx_q[6:0], 1'b0};
                  end
               end
               StRack: begin
                  if (scl_rise) begin
                     if (sda_f == ACK) begin
                        ack_rise_q <= 1'b1;
                        reg_addr   <= reg_addr + 1'b1;
                     end else begin
                        busy    <= 1'b0;
                        state_q <= StWaitStop;
                     end
                  end else if (scl_fall && ack_rise_q) begin
                     ack_rise_q <= 1'b0;
                     bit_cnt_q  <= '0;
                     reg_rd     <= 1'b1;
                     state_q    <= StRdata;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master, a bank behind the strobe
// port and a transaction-level model of the expected bank contents.
module tb_i2c_slave_regs;

   localparam int Q = 10;  // quarter SCL period in clks

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_in;
   logic       sda_out, busy, reg_wr, reg_rd;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;

   logic [7:0] bank [16];
   logic [7:0] init_vals [16];
   logic       load_bank = 1'b0;
   logic [7:0] model_bank [16];
   int         wr_a[$], wr_d[$], rd_a[$];
   int         low_cnt = 0, hi_changes = 0;
   logic       sda_prev = 1'b1;
   int         errors = 0, checks = 0;

   assign sda_in    = sda_m & sda_out;
   assign reg_rdata = bank[reg_addr];

   i2c_slave_regs dut (
      .clk       (clk),
      .rst_      (rst_),
      .scl_in    (scl_m),
      .sda_in    (sda_in),
      .sda_out   (sda_out),
      .busy      (busy),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (load_bank) for (int i = 0; i < 16; i++) bank[i] <= init_vals[i];
      if (reg_wr) begin
         bank[reg_addr] <= reg_wdata;
         wr_a.push_back(int'(reg_addr));
         wr_d.push_back(int'(reg_wdata));
      end
      if (reg_rd) rd_a.push_back(int'(reg_addr));
      if (sda_out === 1'b0) low_cnt <= low_cnt + 1;
      if (rst_ && scl_m && sda_out !== sda_prev) hi_changes <= hi_changes + 1;
      sda_prev <= sda_out;
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q);
      sda_m = 1'b0; clks(Q); scl_m = 1'b0; clks(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; clks(Q); scl_m = 1'b1; clks(Q); sda_m = 1'b1; clks(Q);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      sda_m = b; clks(Q); scl_m = 1'b1; clks(Q);
      if (glitch) begin
         sda_m = ~b; clks(1); sda_m = b; clks(Q - 1);
      end else begin
         clks(Q);
      end
      scl_m = 1'b0; clks(Q);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q);
      b = sda_in; clks(Q); scl_m = 1'b0; clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
      recv_bit(ack);
   endtask

   task automatic read_byte(input logic master_nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(master_nack, 1'b0);
   endtask

   task automatic test_reset();
      rst_ = 1'b0; clks(4);
      checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda_out: got %b want 1", sda_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (reg_addr !== 4'h0) begin errors++; $display("FAIL reset_reg_addr: got %h want 0", reg_addr); end
      checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
      checks++; if ({reg_wr, reg_rd} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {reg_wr, reg_rd}); end
      rst_ = 1'b1; clks(4);
   endtask

   task automatic test_write();
      logic [3:0] a;
      logic       busy_mid;
      int         w0, h0;
      w0 = wr_a.size(); h0 = hi_changes;
      i2c_start();
      write_byte(8'hB4, -1, a[3]); busy_mid = busy;
      write_byte(8'h03, -1, a[2]);
      write_byte(8'h5A, -1, a[1]);
      write_byte(8'hC3, -1, a[0]);
      i2c_stop(); clks(10);
      checks++; if (a !== 4'b0000) begin errors++; $display("FAIL write_acks: got %b want 0000", a); end
      checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b want 1", busy_mid); end
      checks++; if (wr_a.size() !== w0 + 2) begin errors++; $display("FAIL write_count: got %0d want %0d", wr_a.size(), w0 + 2); end
      checks++; if (wr_a[w0] !== 3 || wr_d[w0] !== 'h5A) begin errors++; $display("FAIL write_first: got %0d/%h want 3/5a", wr_a[w0], wr_d[w0]); end
      checks++; if (wr_a[w0+1] !== 4 || wr_d[w0+1] !== 'hC3) begin errors++; $display("FAIL write_second: got %0d/%h want 4/c3", wr_a[w0+1], wr_d[w0+1]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
      checks++; if (hi_changes !== h0) begin errors++; $display("FAIL write_sda_while_scl_high: got %0d want %0d", hi_changes, h0); end
      model_bank[3] = 8'h5A;
      model_bank[4] = 8'hC3;
   endtask

   task automatic test_read();
      logic [2:0] a;
      logic [7:0] d0, d1;
      logic       busy_nack;
      int         r0, h0;
      r0 = rd_a.size(); h0 = hi_changes;
      i2c_start();
      write_byte(8'hB4, -1, a[2]);
      write_byte(8'h0F, -1, a[1]);
      i2c_start();
      write_byte(8'hB5, -1, a[0]);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      busy_nack = busy;
      i2c_stop(); clks(10);
      checks++; if (a !== 3'b000) begin errors++; $display("FAIL read_acks: got %b want 000", a); end
      checks++; if (rd_a.size() !== r0 + 2) begin errors++; $display("FAIL read_count: got %0d want %0d", rd_a.size(), r0 + 2); end
      checks++; if (rd_a[r0] !== 15 || rd_a[r0+1] !== 0) begin errors++; $display("FAIL read_addrs: got %0d,%0d want 15,0", rd_a[r0], rd_a[r0+1]); end
      checks++; if (d0 !== model_bank[15]) begin errors++; $display("FAIL read_data15: got %h want %h", d0, model_bank[15]); end
      checks++; if (d1 !== model_bank[0]) begin errors++; $display("FAIL read_data0: got %h want %h", d1, model_bank[0]); end
      checks++; if (busy_nack !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack: got %b want 0", busy_nack); end
      checks++; if (hi_changes !== h0) begin errors++; $display("FAIL read_sda_while_scl_high: got %0d want %0d", hi_changes, h0); end
   endtask

   task automatic test_mismatch();
      logic [1:0] a;
      logic       busy_mid;
      int         l0, w0, r0;
      l0 = low_cnt; w0 = wr_a.size(); r0 = rd_a.size();
      i2c_start();
      write_byte(8'hB6, -1, a[1]); busy_mid = busy;
      write_byte(8'h11, -1, a[0]);
      i2c_stop(); clks(10);
      checks++; if (a !== 2'b11) begin errors++; $display("FAIL mismatch_nacks: got %b want 11", a); end
      checks++; if (low_cnt !== l0) begin errors++; $display("FAIL mismatch_sda_low: got %0d want %0d", low_cnt, l0); end
      checks++; if (wr_a.size() !== w0 || rd_a.size() !== r0) begin errors++; $display("FAIL mismatch_strobes: got %0d/%0d want %0d/%0d", wr_a.size(), rd_a.size(), w0, r0); end
      checks++; if (busy_mid !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b want 0", busy_mid); end
   endtask

   task automatic test_glitch();
      logic [2:0] a;
      logic [7:0] d;
      int         p, g, w0;
      p = int'($urandom_range(0, 15)); d = 8'($urandom); g = int'($urandom_range(1, 6));
      w0 = wr_a.size();
      i2c_start();
      write_byte(8'hB4, -1, a[2]);
      write_byte(8'(p), -1, a[1]);
      write_byte(d, g, a[0]);
      i2c_stop(); clks(10);
      checks++; if (a !== 3'b000) begin errors++; $display("FAIL glitch_acks: got %b want 000", a); end
      checks++; if (wr_a.size() !== w0 + 1) begin errors++; $display("FAIL glitch_count: got %0d want %0d", wr_a.size(), w0 + 1); end
      checks++; if (wr_a[w0] !== p || wr_d[w0] !== int'(d)) begin errors++; $display("FAIL glitch_write: got %0d/%h want %0d/%h", wr_a[w0], wr_d[w0], p, d); end
      model_bank[p] = d;
   endtask

   task automatic test_reset_mid_read();
      logic [2:0] a;
      logic [2:0] top3;
      logic [7:0] v, d2;
      logic       b, drv_before;
      int         p, q, w0, r0;
      p = int'($urandom_range(0, 15)); v = 8'($urandom) & 8'hEF;
      i2c_start();
      write_byte(8'hB4, -1, a[2]); write_byte(8'(p), -1, a[1]); write_byte(v, -1, a[0]);
      i2c_stop(); clks(10);
      model_bank[p] = v;
      i2c_start();
      write_byte(8'hB4, -1, a[2]); write_byte(8'(p), -1, a[1]);
      i2c_start();
      write_byte(8'hB5, -1, a[0]);
      for (int i = 2; i >= 0; i--) begin
         recv_bit(b);
         top3[i] = b;
      end
      sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q / 2);
      drv_before = sda_out;
      rst_ = 1'b0; clks(1);
      checks++; if (a !== 3'b000) begin errors++; $display("FAIL rstmid_acks: got %b want 000", a); end
      checks++; if (top3 !== v[7:5]) begin errors++; $display("FAIL rstmid_bits: got %b want %b", top3, v[7:5]); end
      checks++; if (drv_before !== 1'b0) begin errors++; $display("FAIL rstmid_bit4_driven: got %b want 0", drv_before); end
      checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL rstmid_sda_release: got %b want 1", sda_out); end
      checks++; if (busy !== 1'b0 || reg_addr !== 4'h0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b addr=%h want 0/0", busy, reg_addr); end
      clks(2);
      rst_ = 1'b1; w0 = wr_a.size(); r0 = rd_a.size();
      scl_m = 1'b0; clks(Q);
      i2c_stop(); clks(10);
      checks++; if (wr_a.size() !== w0 || rd_a.size() !== r0) begin errors++; $display("FAIL rstmid_no_strobes: got %0d/%0d want %0d/%0d", wr_a.size(), rd_a.size(), w0, r0); end
      q = int'($urandom_range(0, 15)); d2 = 8'($urandom);
      i2c_start();
      write_byte(8'hB4, -1, a[2]); write_byte(8'(q), -1, a[1]); write_byte(d2, -1, a[0]);
      i2c_stop(); clks(10);
      checks++; if (a !== 3'b000 || wr_a.size() !== w0 + 1) begin errors++; $display("FAIL rstmid_recover: got acks=%b n=%0d want 000/%0d", a, wr_a.size(), w0 + 1); end
      checks++; if (wr_a[w0] !== q || wr_d[w0] !== int'(d2)) begin errors++; $display("FAIL rstmid_recover_write: got %0d/%h want %0d/%h", wr_a[w0], wr_d[w0], q, d2); end
      model_bank[q] = d2;
   endtask

   task automatic test_early_stop();
      logic [3:0] a;
      logic [7:0] d, rd;
      int         p, nxt, w0, r0;
      p = int'($urandom_range(0, 15)); d = 8'($urandom); nxt = (p + 1) % 16;
      w0 = wr_a.size();
      i2c_start();
      write_byte(8'hB4, -1, a[3]); write_byte(8'(p), -1, a[2]); write_byte(d, -1, a[1]);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
      i2c_stop(); clks(10);
      model_bank[p] = d;
      checks++; if (wr_a.size() !== w0 + 1) begin errors++; $display("FAIL early_stop_count: got %0d want %0d", wr_a.size(), w0 + 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_stop_busy: got %b want 0", busy); end
      r0 = rd_a.size();
      i2c_start();
      write_byte(8'hB5, -1, a[0]);
      read_byte(1'b1, rd);
      i2c_stop(); clks(10);
      checks++; if (a !== 4'b0000) begin errors++; $display("FAIL early_stop_acks: got %b want 0000", a); end
      checks++; if (rd_a[r0] !== nxt) begin errors++; $display("FAIL early_stop_ptr: got %0d want %0d", rd_a[r0], nxt); end
      checks++; if (rd !== model_bank[nxt]) begin errors++; $display("FAIL early_stop_data: got %h want %h", rd, model_bank[nxt]); end
   endtask

   task automatic test_random();
      logic [7:0] dat [4];
      logic [7:0] got;
      logic       ack, ack_any;
      int         p, n, w0, r0, ea;
      bit         is_rd;
      for (int t = 0; t < 6; t++) begin
         is_rd = (t == 0) ? 1'b0 : (t == 1) ? 1'b1 : 1'($urandom);
         p = (t < 2) ? 14 : int'($urandom_range(0, 15));
         n = (t < 2) ? 4 : int'($urandom_range(1, 4));
         w0 = wr_a.size(); r0 = rd_a.size(); ack_any = 1'b0;
         i2c_start();
         write_byte(8'hB4, -1, ack); ack_any |= ack;
         write_byte(8'(p), -1, ack); ack_any |= ack;
         if (!is_rd) begin
            for (int i = 0; i < n; i++) begin
               dat[i] = 8'($urandom);
               write_byte(dat[i], -1, ack); ack_any |= ack;
            end
         end else begin
            i2c_start();
            write_byte(8'hB5, -1, ack); ack_any |= ack;
            for (int i = 0; i < n; i++) read_byte(i == n - 1, dat[i]);
         end
         i2c_stop(); clks(10);
         checks++; if (ack_any !== 1'b0) begin errors++; $display("FAIL rand%0d_acks: got nack want ack", t); end
         if (!is_rd) begin
            checks++; if (wr_a.size() !== w0 + n) begin errors++; $display("FAIL rand%0d_wr_count: got %0d want %0d", t, wr_a.size(), w0 + n); end
            for (int i = 0; i < n; i++) begin
               ea = (p + i) % 16;
               checks++; if (wr_a[w0+i] !== ea || wr_d[w0+i] !== int'(dat[i])) begin errors++; $display("FAIL rand%0d_wr%0d: got %0d/%h want %0d/%h", t, i, wr_a[w0+i], wr_d[w0+i], ea, dat[i]); end
               model_bank[ea] = dat[i];
            end
         end else begin
            checks++; if (rd_a.size() !== r0 + n) begin errors++; $display("FAIL rand%0d_rd_count: got %0d want %0d", t, rd_a.size(), r0 + n); end
            for (int i = 0; i < n; i++) begin
               ea = (p + i) % 16;
               got = dat[i];
               checks++; if (rd_a[r0+i] !== ea || got !== model_bank[ea]) begin errors++; $display("FAIL rand%0d_rd%0d: got %0d/%h want %0d/%h", t, i, rd_a[r0+i], got, ea, model_bank[ea]); end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         init_vals[i]  = 8'($urandom);
         model_bank[i] = init_vals[i];
      end
      load_bank = 1'b1; clks(2); load_bank = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_glitch();
      test_reset_mid_read();
      test_early_stop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
